dest_reg_tracker: RTL and testbench
===================================

# dest_reg_tracker

Pipelined destination-register tracker for the 5-stage MIPS datapath. It carries each instruction's write-register tag and write-enable from decode through EX, MEM and WB. It drives the `reg_wr_mem` / `reg_wr_wb` inputs of the forwarding unit and raises the load-use stall request. It is the producer side of the forwarding interface: the forwarding unit consumes its tags and returns port select codes.

## Interface
- No parameters. Widths come from `cpu_types_pkg`: `regbits_t` is 5 bits.
- `CLK`  in  1  pipeline clock.
- `nRST`  in  1  asynchronous, active-low reset.
- `advance`  in  1  pipeline enable. High means all latches move this cycle (ihit/dhit qualified upstream).
- `flush`  in  1  branch/jump squash. Inserts a bubble into EX on the next advance.
- `id_wsel`  in  5  destination register of the instruction in ID.
- `id_regwen`  in  1  instruction in ID writes the register file.
- `id_memtoreg`  in  1  instruction in ID is a load.
- `id_rs`, `id_rt`  in  5 each  source registers of the instruction in ID.
- `reg_wr_ex`  out  5  EX-stage write tag. 0 when no write.
- `reg_wr_mem`  out  5  MEM-stage write tag. 0 when no write.
- `reg_wr_wb`  out  5  WB-stage write tag. 0 when no write.
- `load_use_stall`  out  1  hold PC/IF-ID and bubble EX.
- `stall_count`  out  32  load-use stall cycle count. Present only with the macro below.

## Operation
- Three stage registers: EX, MEM, WB. Each holds `{valid, load, tag[4:0]}`.
- Capture rule: the EX capture takes `valid = id_regwen && (id_wsel != 0)` and `tag = valid ? id_wsel : 0`.
  - Writes to `$0` are never tracked.
- On a clock edge with `advance=1`:
  - WB gets MEM.
  - MEM gets EX.
  - EX gets the ID capture, or a bubble `{0,0,0}` if `flush || load_use_stall`.
- Priority: `nRST` low, then bubble (`flush` / `load_use_stall`), then normal capture.
- With `advance=0`, all three registers hold. `flush` and stall are ignored on that edge.
- Outputs: `reg_wr_X = valid_X ? tag_X : 0` for each stage.
- `load_use_stall` is combinational from EX state and the ID sources: `valid_ex && load_ex && (tag_ex == id_rs || tag_ex == id_rt)`.
  - Because `$0` is never tracked, a source of 0 never stalls.
- Only one load-use bubble per load. After the bubble the load is in MEM, and the forwarding unit covers it from MEM/WB.
- Reset mid-operation clears all stages at once. No stale tag survives.

## Timing
- Reset values: all stage registers 0, so `reg_wr_ex/mem/wb = 0`, `load_use_stall = 0` and `stall_count = 0`.
- Latency:
  - A tag captured at edge N appears on `reg_wr_ex` after N.
  - It appears on `reg_wr_mem` after the next advancing edge.
  - It appears on `reg_wr_wb` after the advancing edge after that.
- Non-advancing edges add no latency steps.
- `load_use_stall` is valid in the same cycle the dependent instruction sits in ID. There is no registered delay.
- `flush` and `load_use_stall` in the same advancing cycle produce a single bubble. Both are satisfied.
- `advance=0` with `load_use_stall=1`: the stall stays asserted, and the state and counter do not change.

## Configuration
- `DEST_TRACK_STATS_EN`: when defined, `stall_count` exists.
  - Increments by 1 on each edge where `advance && load_use_stall`.
  - Saturates at `32'hFFFF_FFFF`. Cleared only by `nRST`.
- When undefined, the port and counter are absent and the rest of the behaviour is identical.

## Test plan
- Reset: assert `nRST=0` mid-stream with all stages valid -> all `reg_wr_*` = 0 and `load_use_stall` = 0 immediately (asynchronous).
- Propagation: `id_wsel=5`, `id_regwen=1`, `advance=1` for 3 edges -> `reg_wr_ex=5`, then `reg_wr_mem=5`, then `reg_wr_wb=5`. Insert `advance=0` between edges and confirm the values hold.
- `$0` filter: `id_wsel=0`, `id_regwen=1` -> `reg_wr_ex=0` and no stall even with `id_rs=0`.
- Load-use:
  - Load to `$8` in EX, `id_rt=8` -> `load_use_stall=1`.
  - Next advancing edge -> `reg_wr_ex=0` (bubble), `reg_wr_mem=8`, `load_use_stall=0`.
  - With the macro, `stall_count=1`.
- Flush: `flush=1` with `id_wsel=9` valid -> `reg_wr_ex=0` after the edge, while MEM and WB still advance.
- Combined: `flush=1` and a load-use condition on the same edge -> exactly one bubble. `stall_count` increments by 1.

Source files
------------

// File: rtl/dest_reg_tracker.sv
// -----------------------------------------------------------------------------
// dest_reg_tracker
//
// Producer side of the MIPS forwarding interface. Carries each instruction's
// destination-register tag from decode through EX, MEM and WB so the
// forwarding unit can compare against it. It also raises the load-use stall
// request when the instruction in ID reads the destination of a load in EX.
//
// Optional feature macro: DEST_TRACK_STATS_EN
//   When this macro is defined, the stall_count port and its saturating
//   counter are present. When it is undefined, both are removed.
//
// Ports
//   CLK            in   1   pipeline clock
//   nRST           in   1   asynchronous active-low reset
//   advance        in   1   pipeline enable (all latches move this cycle)
//   flush          in   1   branch/jump squash, bubbles EX on next advance
//   id_wsel        in   5   destination register of instruction in ID
//   id_regwen      in   1   instruction in ID writes the register file
//   id_memtoreg    in   1   instruction in ID is a load
//   id_rs, id_rt   in   5   source registers of instruction in ID
//   reg_wr_ex      out  5   EX-stage write tag (0 when no write)
//   reg_wr_mem     out  5   MEM-stage write tag (0 when no write)
//   reg_wr_wb      out  5   WB-stage write tag (0 when no write)
//   load_use_stall out  1   hold PC/IF-ID and bubble EX
//   stall_count    out  32  load-use stall cycles (DEST_TRACK_STATS_EN only)
// -----------------------------------------------------------------------------
module dest_reg_tracker (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       advance,
  input  logic       flush,
  input  logic [4:0] id_wsel,
  input  logic       id_regwen,
  input  logic       id_memtoreg,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  output logic [4:0] reg_wr_ex,
  output logic [4:0] reg_wr_mem,
  output logic [4:0] reg_wr_wb,
  output logic       load_use_stall
`ifdef DEST_TRACK_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);

  typedef logic [4:0] regbits_t;

  // ID capture. Writes to $0 are never tracked, so a zero source can never
  // match a tracked tag.
  logic     cap_vld;
  logic     cap_load;
  regbits_t cap_tag;
  logic     bubble;

  // The load flag is only consulted while the instruction sits in EX. Once a
  // load reaches MEM, the forwarding unit covers it, so the flag is not
  // carried further down the pipe.
  logic     vld_p0, load_p0;
  regbits_t tag_p0;
  logic     vld_p1;
  regbits_t tag_p1;
  logic     vld_p2;
  regbits_t tag_p2;

  always_comb begin
    cap_vld  = id_regwen && (id_wsel != '0);
    cap_load = cap_vld && id_memtoreg;
    cap_tag  = cap_vld ? id_wsel : '0;
  end

  assign load_use_stall = vld_p0 && load_p0 &&
                          ((tag_p0 == id_rs) || (tag_p0 == id_rt));

  // A flush and a load-use stall in the same cycle collapse into one bubble.
  assign bubble = flush || load_use_stall;

  // ---- ID -> EX ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p0  <= 1'b0;
      load_p0 <= 1'b0;
      tag_p0  <= '0;
    end else if (advance) begin
      if (bubble) begin
        vld_p0  <= 1'b0;
        load_p0 <= 1'b0;
        tag_p0  <= '0;
      end else begin
        vld_p0  <= cap_vld;
        load_p0 <= cap_load;
        tag_p0  <= cap_tag;
      end
    end
  end

  // ---- EX -> MEM ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p1 <= 1'b0;
      tag_p1 <= '0;
    end else if (advance) begin
      vld_p1 <= vld_p0;
      tag_p1 <= tag_p0;
    end
  end

  // ---- MEM -> WB ----
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vld_p2 <= 1'b0;
      tag_p2 <= '0;
    end else if (advance) begin
      vld_p2 <= vld_p1;
      tag_p2 <= tag_p1;
    end
  end

  assign reg_wr_ex  = vld_p0 ? tag_p0 : '0;
  assign reg_wr_mem = vld_p1 ? tag_p1 : '0;
  assign reg_wr_wb  = vld_p2 ? tag_p2 : '0;

`ifdef DEST_TRACK_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counts only stall cycles in which the pipeline actually moves, so a
  // stall held across non-advancing edges is counted once per bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_count <= '0;
    end else if (advance && load_use_stall) begin
      stall_count <= sat_inc(stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_dest_reg_tracker.sv
module tb_dest_reg_tracker;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       advance;
  logic       flush;
  logic [4:0] id_wsel;
  logic       id_regwen;
  logic       id_memtoreg;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic [4:0] reg_wr_ex;
  logic [4:0] reg_wr_mem;
  logic [4:0] reg_wr_wb;
  logic       load_use_stall;
`ifdef DEST_TRACK_STATS_EN
  logic [31:0] stall_count;
`endif

  int checks = 0;
  int errors = 0;

  dest_reg_tracker dut (
    .CLK            (CLK),
    .nRST           (nRST),
    .advance        (advance),
    .flush          (flush),
    .id_wsel        (id_wsel),
    .id_regwen      (id_regwen),
    .id_memtoreg    (id_memtoreg),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .reg_wr_ex      (reg_wr_ex),
    .reg_wr_mem     (reg_wr_mem),
    .reg_wr_wb      (reg_wr_wb),
    .load_use_stall (load_use_stall)
`ifdef DEST_TRACK_STATS_EN
    ,
    .stall_count    (stall_count)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_stages(input string tag, input logic [4:0] ex,
                              input logic [4:0] mem, input logic [4:0] wb);
    check({tag, "_ex"},  {27'd0, reg_wr_ex},  {27'd0, ex});
    check({tag, "_mem"}, {27'd0, reg_wr_mem}, {27'd0, mem});
    check({tag, "_wb"},  {27'd0, reg_wr_wb},  {27'd0, wb});
  endtask

  task automatic check_stall(input string tag, input logic exp);
    check(tag, {31'd0, load_use_stall}, {31'd0, exp});
  endtask

  task automatic check_count(input string tag, input logic [31:0] exp);
`ifdef DEST_TRACK_STATS_EN
    check(tag, stall_count, exp);
`endif
  endtask

  // One clock edge, with outputs sampled 1 time unit after it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_id(input logic [4:0] wsel, input logic regwen, input logic load,
                          input logic [4:0] rs, input logic [4:0] rt);
    id_wsel     = wsel;
    id_regwen   = regwen;
    id_memtoreg = load;
    id_rs       = rs;
    id_rt       = rt;
  endtask

  initial begin
    nRST    = 1'b0;
    advance = 1'b0;
    flush   = 1'b0;
    drive_id(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);

    // Reset state
    #12;
    check_stages("reset", 5'd0, 5'd0, 5'd0);
    check_stall("reset_stall", 1'b0);
    check_count("reset_count", 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Propagation with holds between advancing edges
    @(negedge CLK);
    advance = 1'b1;
    drive_id(5'd5, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    check_stages("prop1", 5'd5, 5'd0, 5'd0);
    advance = 1'b0;
    drive_id(5'd0, 1'b0, 1'b0, 5'd0, 5'd0);
    step();
    check_stages("hold1", 5'd5, 5'd0, 5'd0);
    advance = 1'b1;
    step();
    check_stages("prop2", 5'd0, 5'd5, 5'd0);
    advance = 1'b0;
    step();
    check_stages("hold2", 5'd0, 5'd5, 5'd0);
    advance = 1'b1;
    step();
    check_stages("prop3", 5'd0, 5'd0, 5'd5);

    // $0 filter: a load to $0 is not tracked and a zero source does not stall
    drive_id(5'd0, 1'b1, 1'b1, 5'd0, 5'd0);
    step();
    check_stages("zero", 5'd0, 5'd0, 5'd0);
    check_stall("zero_stall", 1'b0);

    // Load-use: load to $8, then a consumer of $8 in ID
    drive_id(5'd8, 1'b1, 1'b1, 5'd0, 5'd0);
    step();
    check_stages("ld", 5'd8, 5'd0, 5'd0);
    check_stall("ld_nodep", 1'b0);
    drive_id(5'd10, 1'b1, 1'b0, 5'd0, 5'd8);
    #1;
    check_stall("ld_dep", 1'b1);
    advance = 1'b0;
    step();
    check_stall("ld_dep_hold", 1'b1);
    check_stages("ld_hold", 5'd8, 5'd0, 5'd0);
    check_count("ld_hold_count", 32'd0);
    advance = 1'b1;
    step();
    check_stages("ld_bubble", 5'd0, 5'd8, 5'd0);
    check_stall("ld_after", 1'b0);
    check_count("ld_count", 32'd1);

    // Flush squashes the ID capture while MEM/WB still advance
    drive_id(5'd9, 1'b1, 1'b0, 5'd0, 5'd0);
    flush = 1'b1;
    step();
    check_stages("flush", 5'd0, 5'd0, 5'd8);
    flush = 1'b0;
    step();
    check_stages("post_flush", 5'd9, 5'd0, 5'd0);

    // Flush together with load-use gives a single bubble
    drive_id(5'd12, 1'b1, 1'b1, 5'd0, 5'd0);
    step();
    check_stages("ld2", 5'd12, 5'd9, 5'd0);
    drive_id(5'd13, 1'b1, 1'b0, 5'd12, 5'd0);
    flush = 1'b1;
    #1;
    check_stall("comb_stall", 1'b1);
    step();
    check_stages("comb", 5'd0, 5'd12, 5'd9);
    check_stall("comb_after", 1'b0);
    check_count("comb_count", 32'd2);
    flush = 1'b0;

    // Asynchronous reset mid-stream with all stages valid and a stall pending
    drive_id(5'd1, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    drive_id(5'd2, 1'b1, 1'b0, 5'd0, 5'd0);
    step();
    drive_id(5'd3, 1'b1, 1'b1, 5'd0, 5'd0);
    step();
    check_stages("fill", 5'd3, 5'd2, 5'd1);
    id_rs = 5'd3;
    #1;
    check_stall("fill_stall", 1'b1);
    #1;
    nRST = 1'b0;
    #1;
    check_stages("async_rst", 5'd0, 5'd0, 5'd0);
    check_stall("async_rst_stall", 1'b0);
    check_count("async_rst_count", 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    advance = 1'b0;
    step();
    check_stages("rst_release", 5'd0, 5'd0, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
